// File: rtl/traffic_pkg.sv
// Shared constants for the traffic light control slice.
// Defaults used by the vehicle-detect conditioning stage.
package traffic_pkg;

  // Consecutive stable synchronised samples needed to accept a level change.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

  // Width of each per-direction saturating wait counter.
  localparam int unsigned WAIT_W_DEF = 8;

  // Wait count at or above which a direction is flagged as starved.
  localparam int unsigned MAX_WAIT_DEF = 200;

  // Direction index used when the two channels are handled as a pair.
  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

endpackage : traffic_pkg

// File: rtl/detect_channel.sv
// One direction of vehicle-detect conditioning.
// The raw loop sensor passes through a 2-flop synchroniser and then a
// debouncer. A debounced arrival sets a request latch that is cleared
// only by that direction's green. While the request is pending, a
// saturating wait counter runs and drives a starvation flag.
module detect_channel
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned WAIT_W          = WAIT_W_DEF,
  parameter int unsigned MAX_WAIT        = MAX_WAIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sensor_raw,
  input  logic              i_green,
  output logic              o_vehicle_detect,
  output logic [WAIT_W-1:0] o_wait_count,
  output logic              o_starved
);

  // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = '1;
  localparam logic [WAIT_W-1:0] WAIT_STRV = WAIT_W'(MAX_WAIT);

  // Reject illegal parameterisations when the design is elaborated.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
    $error("detect_channel: DEBOUNCE_CYCLES must be in 1..15");
  end
  if (MAX_WAIT >= (1 << WAIT_W)) begin : g_bad_max_wait
    $error("detect_channel: MAX_WAIT must be below 2**WAIT_W");
  end

  // Synchroniser stages.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Debounced level and the run-length counter guarding it.
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Latched service request and the time it has been waiting.
  logic              req_q,  req_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  // Next-state logic for synchroniser, debouncer, request latch and wait counter.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    sync1_d  = i_sensor_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    wait_d   = wait_q;

    // Debounce: the synchronised level must disagree with the stable
    // level for DEBOUNCE_CYCLES consecutive samples before it is taken.
    // Any agreeing sample restarts the run, so short glitches vanish.
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Green wins over a present vehicle: the vehicle is being served.
    // Once green drops, a still-present vehicle re-requests next edge.
    if (i_green) begin
      req_d = 1'b0;
    end else begin
      req_d = req_q | stable_q;
    end

    // The wait counter counts only while the request was already pending
    // and stays pending. The first increment therefore lands one edge
    // after the request rises, and the counter clears on the same edge
    // that green drops the request. At all-ones it holds.
    if (req_q && req_d) begin
      if (wait_q != WAIT_SAT) begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end else begin
      wait_d = '0;
    end
  end

  // State registers. An asynchronous reset clears every flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge value of the others; blocking would collapse the
      // synchroniser into a single stage.
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      wait_q   <= wait_d;
    end
  end

  assign o_vehicle_detect = req_q;
  assign o_wait_count     = wait_q;

  // Starvation is a plain compare on the wait register, so it follows
  // the counter exactly, including its clear on service.
  assign o_starved = (wait_q >= WAIT_STRV);

endmodule : detect_channel

// File: rtl/vehicle_detect_cond.sv
// Vehicle-detect conditioning for the traffic light control engine.
// Two identical, independent detect channels: one for NS, one for EW.
// Each turns a raw loop sensor into a latched service request with a
// wait counter and a starvation flag.
module vehicle_detect_cond
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned WAIT_W          = WAIT_W_DEF,
  parameter int unsigned MAX_WAIT        = MAX_WAIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ns_sensor_raw,
  input  logic              i_ew_sensor_raw,
  input  logic              i_ns_green,
  input  logic              i_ew_green,
  output logic              o_ns_vehicle_detect,
  output logic              o_ew_vehicle_detect,
  output logic [WAIT_W-1:0] o_ns_wait_count,
  output logic [WAIT_W-1:0] o_ew_wait_count,
  output logic              o_ns_starved,
  output logic              o_ew_starved
);

  // North-south channel.
  detect_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .WAIT_W          (WAIT_W),
    .MAX_WAIT        (MAX_WAIT)
  ) u_ns (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_sensor_raw     (i_ns_sensor_raw),
    .i_green          (i_ns_green),
    .o_vehicle_detect (o_ns_vehicle_detect),
    .o_wait_count     (o_ns_wait_count),
    .o_starved        (o_ns_starved)
  );

  // East-west channel.
  detect_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .WAIT_W          (WAIT_W),
    .MAX_WAIT        (MAX_WAIT)
  ) u_ew (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_sensor_raw     (i_ew_sensor_raw),
    .i_green          (i_ew_green),
    .o_vehicle_detect (o_ew_vehicle_detect),
    .o_wait_count     (o_ew_wait_count),
    .o_starved        (o_ew_starved)
  );

endmodule : vehicle_detect_cond

// File: tb/tb_vehicle_detect_cond.sv
// Self-checking bench for vehicle_detect_cond at default parameters.
// A hand-written vector table covers reset release, latency and service.
// Hand sequences cover glitches, saturation and mid-operation reset.
// Random and free-running stimulus is compared every edge against a
// window-based reference model.
`timescale 1ns/100ps
module tb_vehicle_detect_cond;

  localparam int D     = 4;
  localparam int WMAX  = 255;
  localparam int MAXW  = 200;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       ns_raw = 1'b0;
  logic       ew_raw = 1'b0;
  logic       ns_green = 1'b0;
  logic       ew_green = 1'b0;
  logic       o_ns_det, o_ew_det;
  logic [7:0] o_ns_wait, o_ew_wait;
  logic       o_ns_starved, o_ew_starved;

  int n_checks = 0;
  int n_errors = 0;

  vehicle_detect_cond dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_ns_sensor_raw     (ns_raw),
    .i_ew_sensor_raw     (ew_raw),
    .i_ns_green          (ns_green),
    .i_ew_green          (ew_green),
    .o_ns_vehicle_detect (o_ns_det),
    .o_ew_vehicle_detect (o_ew_det),
    .o_ns_wait_count     (o_ns_wait),
    .o_ew_wait_count     (o_ew_wait),
    .o_ns_starved        (o_ns_starved),
    .o_ew_starved        (o_ew_starved)
  );

  always #5 i_clk = ~i_clk;

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Per channel: raw value seen at each past edge, the debounced level,
  // the request and the wait count. The debounced level flips when the
  // last D synchronised samples (raw delayed by two edges) all disagree.
  bit m_stable[2];
  bit m_req[2];
  int m_wait[2];
  bit hist[2][$];

  function automatic void model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_stable[ch] = 1'b0;
      m_req[ch]    = 1'b0;
      m_wait[ch]   = 0;
      hist[ch].delete();
      for (int j = 0; j < D + 2; j++) hist[ch].push_back(1'b0);
    end
  endfunction

  function automatic void model_edge(int ch, bit raw, bit green);
    bit flip;
    bit old_stable;
    bit old_req;
    int n;
    flip       = 1'b1;
    old_stable = m_stable[ch];
    old_req    = m_req[ch];
    n          = hist[ch].size();
    for (int j = 0; j < D; j++)
      if (hist[ch][n - 2 - j] == old_stable) flip = 1'b0;
    if (flip) m_stable[ch] = !old_stable;
    m_req[ch]  = green ? 1'b0 : (old_req | old_stable);
    m_wait[ch] = (old_req && !green) ? ((m_wait[ch] + 1 > WMAX) ? WMAX : m_wait[ch] + 1) : 0;
    hist[ch].push_back(raw);
    if (hist[ch].size() > D + 4) void'(hist[ch].pop_front());
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_ns_det"},     int'(o_ns_det),     int'(m_req[0]));
    check({tag, "_ew_det"},     int'(o_ew_det),     int'(m_req[1]));
    check({tag, "_ns_wait"},    int'(o_ns_wait),    m_wait[0]);
    check({tag, "_ew_wait"},    int'(o_ew_wait),    m_wait[1]);
    check({tag, "_ns_starved"}, int'(o_ns_starved), int'(m_wait[0] >= MAXW));
    check({tag, "_ew_starved"}, int'(o_ew_starved), int'(m_wait[1] >= MAXW));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ns_det"},  int'(o_ns_det),     0);
    check({tag, "_ew_det"},  int'(o_ew_det),     0);
    check({tag, "_ns_wait"}, int'(o_ns_wait),    0);
    check({tag, "_ew_wait"}, int'(o_ew_wait),    0);
    check({tag, "_ns_strv"}, int'(o_ns_starved), 0);
    check({tag, "_ew_strv"}, int'(o_ew_starved), 0);
  endtask

  // One clock edge: advance the model with the inputs present at the
  // edge, then compare 1 ns later. Returns at posedge+1.
  task automatic tick(input string tag);
    @(posedge i_clk);
    if (!i_rst_n) model_reset();
    else begin
      model_edge(0, ns_raw, ns_green);
      model_edge(1, ew_raw, ew_green);
    end
    #1;
    compare_model(tag);
  endtask

  // Assert reset with the given raw levels, check outputs, release.
  task automatic do_reset(input bit ns_r, input bit ew_r);
    ns_green = 1'b0;
    ew_green = 1'b0;
    ns_raw   = ns_r;
    ew_raw   = ew_r;
    i_rst_n  = 1'b0;
    #1;
    check_all_zero("rst");
    model_reset();
    tick("rst_hold");
    tick("rst_hold");
    i_rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit ns_raw;
    bit ew_raw;
    bit ns_g;
    bit ew_g;
    bit exp_ns_det;
    bit exp_ew_det;
    int exp_ns_wait;
    int exp_ew_wait;
  } vec_t;

  function automatic vec_t mk(bit nr, bit er, bit ng, bit eg, bit nd, bit ed, int nw, int ew);
    vec_t v;
    v.ns_raw = nr; v.ew_raw = er; v.ns_g = ng; v.ew_g = eg;
    v.exp_ns_det = nd; v.exp_ew_det = ed; v.exp_ns_wait = nw; v.exp_ew_wait = ew;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    int  rise_wait;
    bit  seen;
    int  guard;

    // Edge numbers count from the first edge after reset release.
    // Both sensors are held present, so both requests rise at edge 7.
    for (int i = 0; i < 6; i++) vecs[i] = mk(1, 1, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 1, 0, 0, 1, 1, 0, 0);
    vecs[7]  = mk(1, 1, 0, 0, 1, 1, 1, 1);
    vecs[8]  = mk(1, 1, 1, 0, 0, 1, 0, 2);  // NS served
    vecs[9]  = mk(1, 1, 1, 0, 0, 1, 0, 3);  // NS green held
    vecs[10] = mk(1, 1, 0, 0, 1, 1, 0, 4);  // NS re-requests
    vecs[11] = mk(1, 1, 0, 1, 1, 0, 1, 0);  // EW served
    vecs[12] = mk(1, 1, 0, 0, 1, 1, 2, 0);  // EW re-requests

    // Reset with both sensors high, then latency/service table.
    model_reset();
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 13; i++) begin
      ns_raw   = vecs[i].ns_raw;
      ew_raw   = vecs[i].ew_raw;
      ns_green = vecs[i].ns_g;
      ew_green = vecs[i].ew_g;
      tick("tbl");
      check($sformatf("vec%0d_ns_det", i + 1),  int'(o_ns_det),  int'(vecs[i].exp_ns_det));
      check($sformatf("vec%0d_ew_det", i + 1),  int'(o_ew_det),  int'(vecs[i].exp_ew_det));
      check($sformatf("vec%0d_ns_wait", i + 1), int'(o_ns_wait), vecs[i].exp_ns_wait);
      check($sformatf("vec%0d_ew_wait", i + 1), int'(o_ew_wait), vecs[i].exp_ew_wait);
    end

    // Glitch reject: 3-cycle NS pulse never requests.
    do_reset(1'b0, 1'b0);
    repeat (3) tick("g3_pre");
    ns_raw = 1'b1;
    repeat (3) tick("g3_hi");
    ns_raw = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      tick("g3_lo");
      if (o_ns_det) seen = 1'b1;
    end
    check("glitch3_no_request", int'(seen), 0);

    // 5-cycle pulse is accepted and stays latched after the sensor drops.
    ns_raw = 1'b1;
    repeat (5) tick("g5_hi");
    ns_raw = 1'b0;
    repeat (12) tick("g5_lo");
    check("glitch5_latched", int'(o_ns_det), 1);
    check("glitch5_ew_idle", int'(o_ew_det), 0);

    // One-cycle green with the sensor low clears request and wait.
    ns_green = 1'b1;
    tick("svc");
    check("svc_ns_det", int'(o_ns_det), 0);
    check("svc_ns_wait", int'(o_ns_wait), 0);
    ns_green = 1'b0;
    repeat (4) tick("svc_after");
    check("svc_no_relatch", int'(o_ns_det), 0);

    // Saturation and starvation on EW.
    do_reset(1'b0, 1'b1);
    rise_wait = -1;
    for (int i = 0; i < 600; i++) begin
      tick("sat");
      if (o_ew_starved && rise_wait < 0) rise_wait = int'(o_ew_wait);
    end
    check("starve_rises_at", rise_wait, MAXW);
    check("sat_hold_255", int'(o_ew_wait), WMAX);
    check("sat_starved", int'(o_ew_starved), 1);
    check("sat_ns_untouched", int'(o_ns_wait), 0);
    ew_green = 1'b1;
    tick("sat_svc");
    check("sat_svc_wait", int'(o_ew_wait), 0);
    check("sat_svc_starved", int'(o_ew_starved), 0);
    ew_green = 1'b0;

    // Independence: free-running sensor toggles at 26 ns and 40 ns
    // periods, off the clock grid, with occasional green pulses.
    do_reset(1'b0, 1'b0);
    fork
      begin
        #1.5;
        repeat (230) begin ns_raw = ~ns_raw; #13; end
      end
      begin
        #1.5;
        repeat (150) begin ew_raw = ~ew_raw; #20; end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          ns_green = ($urandom_range(0, 9) == 0);
          ew_green = ($urandom_range(0, 6) == 0);
          tick("indep");
        end
      end
    join
    ns_green = 1'b0;
    ew_green = 1'b0;

    // Random stimulus against the model.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) ns_raw = ~ns_raw;
      if ($urandom_range(0, 5) == 0) ew_raw = ~ew_raw;
      ns_green = ($urandom_range(0, 19) == 0);
      ew_green = ($urandom_range(0, 14) == 0);
      tick("rand");
    end
    ns_green = 1'b0;
    ew_green = 1'b0;

    // Mid-operation reset between edges with both waits at 50.
    do_reset(1'b1, 1'b1);
    guard = 0;
    while (m_wait[0] != 50 && guard < 200) begin
      tick("mid_run");
      guard++;
    end
    check("mid_ns_wait50", int'(o_ns_wait), 50);
    check("mid_ew_wait50", int'(o_ew_wait), 50);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("mid_async");
    model_reset();
    ns_raw = 1'b0;
    ew_raw = 1'b0;
    tick("mid_hold");
    i_rst_n = 1'b1;
    repeat (10) tick("mid_after");
    check("mid_not_restored", int'(o_ns_det | o_ew_det), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_vehicle_detect_cond
